// File: rtl/min_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : min_pkg                                                |
// | Description : Shared types and default sizing for the frame minimum |
// |               tracker and its compare/select helper.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package min_pkg;

  // Default sample width (unsigned samples)
  localparam int DEF_W       = 8;
  // Default maximum frame length; a frame is force-closed at this count
  localparam int DEF_MAX_LEN = 16;

  // Frame tracker control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for the first sample of a frame
    ST_ACC  = 2'd1,  // accumulating samples of an open frame
    ST_HOLD = 2'd2   // result presented, waiting for downstream accept
  } state_t;

endpackage : min_pkg
`default_nettype wire

// File: rtl/min2_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : min2_sel                                               |
// | Description : Two-input unsigned minimum selector. Reports whether   |
// |               y is strictly below x, and passes the smaller value.   |
// |               Ties select x, so an earlier incumbent is kept.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module min2_sel
  import min_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         lt,
  output logic [W-1:0] min
);

  // Strict unsigned compare: equal values do not displace the incumbent
  assign lt  = (y < x);
  assign min = lt ? y : x;

endmodule : min2_sel
`default_nettype wire

// File: rtl/frame_min_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : frame_min_tracker                                      |
// | Description : Streaming per-frame minimum finder. Accepts framed     |
// |               unsigned samples over valid/ready and reports the      |
// |               smallest value, its first index, the sample count and  |
// |               whether the frame was closed by the length limit.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module frame_min_tracker
  import min_pkg::*;
#(
  parameter  int W       = DEF_W,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  localparam int IW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  // sample input
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  // result output
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_min,
  output logic [IW-1:0] out_idx,
  output logic [IW:0]   out_cnt,
  output logic          out_trunc
);

  // Sample count at which an open frame is force-closed
  localparam logic [IW:0] c_max_cnt = (IW+1)'(MAX_LEN);

  // ------------------------------------------------------------------
  // State and accumulators
  // ------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_min_acc;
  logic [W-1:0]  w_min_acc_nxt;
  logic [IW-1:0] r_idx_acc;
  logic [IW-1:0] w_idx_acc_nxt;
  logic [IW:0]   r_cnt;
  logic [IW:0]   w_cnt_nxt;

  // Output register stage
  logic          r_out_valid;
  logic          w_out_valid_nxt;
  logic [W-1:0]  r_out_min;
  logic [W-1:0]  w_out_min_nxt;
  logic [IW-1:0] r_out_idx;
  logic [IW-1:0] w_out_idx_nxt;
  logic [IW:0]   r_out_cnt;
  logic [IW:0]   w_out_cnt_nxt;
  logic          r_out_trunc;
  logic          w_out_trunc_nxt;

  // Datapath helpers
  logic          w_ready;
  logic          w_xfer;
  logic          w_lt;
  logic [W-1:0]  w_sel_min;
  logic [IW-1:0] w_sel_idx;
  logic [IW:0]   w_cnt_inc;
  logic          w_at_max;

  // Input is accepted in every state except while a result is pending
  assign w_ready = (r_state != ST_HOLD);
  assign w_xfer  = in_valid && w_ready;

  // Compare the incoming sample against the running minimum
  min2_sel #(
    .W (W)
  ) u_min2_sel (
    .x   (r_min_acc),
    .y   (in_data),
    .lt  (w_lt),
    .min (w_sel_min)
  );

  // The pre-increment count is the 0-based position of the current sample;
  // in ACC it is at most MAX_LEN-1 and so fits the index width.
  assign w_sel_idx = w_lt ? r_cnt[IW-1:0] : r_idx_acc;
  assign w_cnt_inc = r_cnt + (IW+1)'(1);
  assign w_at_max  = (w_cnt_inc == c_max_cnt);

  // Next-state, accumulator and output-stage decisions
  always_comb begin
    w_state_nxt     = r_state;
    w_min_acc_nxt   = r_min_acc;
    w_idx_acc_nxt   = r_idx_acc;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_out_min_nxt   = r_out_min;
    w_out_idx_nxt   = r_out_idx;
    w_out_cnt_nxt   = r_out_cnt;
    w_out_trunc_nxt = r_out_trunc;

    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          // First sample seeds the frame unconditionally
          w_min_acc_nxt = in_data;
          w_idx_acc_nxt = '0;
          w_cnt_nxt     = (IW+1)'(1);
          if (in_last) begin
            // Single-sample frame closes on its first beat
            w_out_valid_nxt = 1'b1;
            w_out_min_nxt   = in_data;
            w_out_idx_nxt   = '0;
            w_out_cnt_nxt   = (IW+1)'(1);
            w_out_trunc_nxt = 1'b0;
            w_state_nxt     = ST_HOLD;
          end else begin
            w_state_nxt     = ST_ACC;
          end
        end
      end

      ST_ACC: begin
        if (w_xfer) begin
          w_min_acc_nxt = w_sel_min;
          w_idx_acc_nxt = w_sel_idx;
          w_cnt_nxt     = w_cnt_inc;
          if (in_last || w_at_max) begin
            // Closing sample's own comparison is included in the result
            w_out_valid_nxt = 1'b1;
            w_out_min_nxt   = w_sel_min;
            w_out_idx_nxt   = w_sel_idx;
            w_out_cnt_nxt   = w_cnt_inc;
            // A sample that is both the limit and last is a normal close
            w_out_trunc_nxt = w_at_max && !in_last;
            w_state_nxt     = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          // Result taken: release input on the following edge
          w_out_valid_nxt = 1'b0;
          w_min_acc_nxt   = '0;
          w_idx_acc_nxt   = '0;
          w_cnt_nxt       = '0;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator and output register stage; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_acc   <= '0;
      r_idx_acc   <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_min   <= '0;
      r_out_idx   <= '0;
      r_out_cnt   <= '0;
      r_out_trunc <= 1'b0;
    end else begin
      r_min_acc   <= w_min_acc_nxt;
      r_idx_acc   <= w_idx_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_min   <= w_out_min_nxt;
      r_out_idx   <= w_out_idx_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_out_trunc <= w_out_trunc_nxt;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_min   = r_out_min;
  assign out_idx   = r_out_idx;
  assign out_cnt   = r_out_cnt;
  assign out_trunc = r_out_trunc;

endmodule : frame_min_tracker
`default_nettype wire

// File: tb/tb_frame_min_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_frame_min_tracker                                   |
// | Description : Directed self-checking bench for frame_min_tracker     |
// |               with hand-computed expected results.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_frame_min_tracker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_min;
  logic [3:0] out_idx;
  logic [4:0] out_cnt;
  logic       out_trunc;

  int checks   = 0;
  int failures = 0;

  frame_min_tracker #(
    .W       (8),
    .MAX_LEN (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_idx   (out_idx),
    .out_cnt   (out_cnt),
    .out_trunc (out_trunc)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until it transfers
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h5A;
  endtask

  task automatic check_result(input string tag, input logic [7:0] m, input logic [3:0] ix,
                              input logic [4:0] c, input logic t);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_min"},   {24'd0, out_min},   {24'd0, m});
    chk({tag, "_idx"},   {28'd0, out_idx},   {28'd0, ix});
    chk({tag, "_cnt"},   {27'd0, out_cnt},   {27'd0, c});
    chk({tag, "_trunc"}, {31'd0, out_trunc}, {31'd0, t});
  endtask

  // Accept the pending result and confirm the handshake clears
  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_acc_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_acc_ready"}, {31'd0, in_ready},  32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready},  32'd1);
    chk("rst_min",   {24'd0, out_min},   32'd0);
    chk("rst_idx",   {28'd0, out_idx},   32'd0);
    chk("rst_cnt",   {27'd0, out_cnt},   32'd0);
    chk("rst_trunc", {31'd0, out_trunc}, 32'd0);

    // 1: 9,3,7,3,5 -> min 3 at idx 1, count 5; result one cycle after last
    out_ready = 1'b1;
    send(8'd9, 1'b0);
    send(8'd3, 1'b0);
    send(8'd7, 1'b0);
    send(8'd3, 1'b0);
    chk("t1_not_early", {31'd0, out_valid}, 32'd0);
    send(8'd5, 1'b1);
    check_result("t1", 8'd3, 4'd1, 5'd5, 1'b0);
    tick();
    chk("t1_acc_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_acc_ready", {31'd0, in_ready},  32'd1);
    out_ready = 1'b0;

    // 2: single-sample frame
    send(8'hAA, 1'b1);
    check_result("t2", 8'hAA, 4'd0, 5'd1, 1'b0);
    chk("t2_hold_ready", {31'd0, in_ready}, 32'd0);
    accept("t2");

    // 3: 20..1 without last; truncation at 16 then the remaining 4..1 frame
    for (int i = 0; i < 16; i++) begin
      send(8'(20 - i), 1'b0);
    end
    check_result("t3a", 8'd5, 4'd15, 5'd16, 1'b1);
    accept("t3a");
    send(8'd4, 1'b0);
    send(8'd3, 1'b0);
    send(8'd2, 1'b0);
    send(8'd1, 1'b1);
    check_result("t3b", 8'd1, 4'd3, 5'd4, 1'b0);
    accept("t3b");

    // 4: back-pressure for 5 cycles on frame 0x40,0x10,0x30
    send(8'h40, 1'b0);
    send(8'h10, 1'b0);
    send(8'h30, 1'b1);
    check_result("t4", 8'h10, 4'd1, 5'd3, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_ready", {31'd0, in_ready},  32'd0);
      chk("t4_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_stall_min",   {24'd0, out_min},   32'h10);
      chk("t4_stall_idx",   {28'd0, out_idx},   32'd1);
      chk("t4_stall_cnt",   {27'd0, out_cnt},   32'd3);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    accept("t4");

    // 5: reset mid-frame after 8,2; then 4,9
    send(8'd8, 1'b0);
    send(8'd2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_ready", {31'd0, in_ready},  32'd1);
    chk("t5_rst_min",   {24'd0, out_min},   32'd0);
    chk("t5_rst_idx",   {28'd0, out_idx},   32'd0);
    chk("t5_rst_cnt",   {27'd0, out_cnt},   32'd0);
    chk("t5_rst_trunc", {31'd0, out_trunc}, 32'd0);
    tick();
    chk("t5_no_result", {31'd0, out_valid}, 32'd0);
    send(8'd4, 1'b0);
    send(8'd9, 1'b1);
    check_result("t5", 8'd4, 4'd0, 5'd2, 1'b0);
    accept("t5");

    // 6: gapped valid with junk on data/last between beats
    send(8'hFF, 1'b0);
    in_data = 8'h01;
    in_last = 1'b1;
    tick();
    tick();
    in_last = 1'b0;
    send(8'h00, 1'b0);
    in_data = 8'h02;
    in_last = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_gap_valid", {31'd0, out_valid}, 32'd0);
    in_last = 1'b0;
    send(8'hFF, 1'b1);
    check_result("t6a", 8'h00, 4'd1, 5'd3, 1'b0);
    accept("t6a");
    send(8'd7, 1'b0);
    send(8'd7, 1'b0);
    send(8'd7, 1'b1);
    check_result("t6b", 8'd7, 4'd0, 5'd3, 1'b0);
    accept("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_frame_min_tracker
`default_nettype wire
